// File: rtl/tmds_stream_serializer.sv
// tmds_stream_serializer
// Buffers NUM_CHANNELS x 10-bit TMDS words in a small FIFO and serializes
// them at BITS_PER_CYCLE bits per clock per channel, LSB first, alongside
// a matching pixel-clock lane pattern (5 ones, 5 zeros per word).
// Optional feature: define TMDS_SERIALIZER_UNDERFLOW_COUNT_EN to add a
// 16-bit saturating underflow_count output.
module tmds_stream_serializer #(
   parameter int          NUM_CHANNELS   = 3,
   parameter int          BITS_PER_CYCLE = 2,
   parameter int          FIFO_DEPTH     = 4,
   parameter logic [9:0]  IDLE_WORD      = 10'b1101010100
) (
   input  logic                                   clk_pixel_x5,
   input  logic                                   reset,
   input  logic                                   enable,
   input  logic                                   word_valid,
   output logic                                   word_ready,
   input  logic [NUM_CHANNELS*10-1:0]             tmds_internal,
   output logic [NUM_CHANNELS*BITS_PER_CYCLE-1:0] tmds_lane,
   output logic [BITS_PER_CYCLE-1:0]              tmds_clock_lane,
   output logic [$clog2(FIFO_DEPTH):0]            fifo_level,
   output logic                                   underflow
`ifdef TMDS_SERIALIZER_UNDERFLOW_COUNT_EN
   ,
   output logic [15:0]                            underflow_count
`endif
);

   localparam int          WORD_CYCLES = 10 / BITS_PER_CYCLE;
   localparam int          PW          = $clog2(WORD_CYCLES);
   localparam int          AW          = $clog2(FIFO_DEPTH);
   localparam int          LW          = AW + 1;
   localparam logic [9:0]  CLOCK_WORD  = 10'b0000011111;
   localparam logic [PW-1:0] LAST_PHASE = PW'(WORD_CYCLES - 1);
   localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

   if (BITS_PER_CYCLE != 1 && BITS_PER_CYCLE != 2) begin : g_bad_bits
      $error("BITS_PER_CYCLE must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two in 2..16");
   end

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } state_t;

   state_t                               state;
   logic [PW-1:0]                        phase;
   logic                                 boundary;

   logic [NUM_CHANNELS*10-1:0]           mem [FIFO_DEPTH];
   logic [AW-1:0]                        rd_ptr;
   logic [AW-1:0]                        wr_ptr;
   logic [LW-1:0]                        level;
   logic                                 fifo_empty;
   logic                                 push;
   logic                                 pop;
   logic                                 underflow_event;

   logic [NUM_CHANNELS-1:0][9:0]         shift_reg;
   logic [9:0]                           clock_shift;

   assign boundary        = (phase == LAST_PHASE);
   assign fifo_empty      = (level == '0);
   assign word_ready      = (level != FULL_LEVEL);
   assign push            = word_valid && word_ready;
   // Both states take the head word at a boundary whenever running is requested
   // and a word is already stored (the empty test uses the registered level,
   // so a word written this cycle cannot be taken until the next one).
   assign pop             = boundary && enable && !fifo_empty;
   assign underflow_event = boundary && (state == ST_RUN) && enable && fifo_empty;
   assign fifo_level      = level;

   // Phase counter marks word boundaries.
   always_ff @(posedge clk_pixel_x5 or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      if (reset) begin
         phase <= '0;
      end else if (boundary) begin
         phase <= '0;
      end else begin
         phase <= phase + PW'(1);
      end
   end

   // FIFO storage array.
   always_ff @(posedge clk_pixel_x5) begin
      // NOTE: the storage array is deliberately not reset; the pointers and
      // level define which entries are meaningful, so stale data is never read.
      if (push) begin
         mem[wr_ptr] <= tmds_internal;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth.
   always_ff @(posedge clk_pixel_x5 or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   // Run/idle control and sticky underflow reporting.
   always_ff @(posedge clk_pixel_x5 or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         underflow <= 1'b0;
`ifdef TMDS_SERIALIZER_UNDERFLOW_COUNT_EN
         underflow_count <= '0;
`endif
      end else begin
         if (boundary) begin
            case (state)
               ST_IDLE: begin
                  if (pop) begin
                     state <= ST_RUN;
                  end
               end
               ST_RUN: begin
                  if (!enable) begin
                     state <= ST_IDLE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
         if (underflow_event) begin
            underflow <= 1'b1;
         end
`ifdef TMDS_SERIALIZER_UNDERFLOW_COUNT_EN
         if (underflow_event && underflow_count != 16'hFFFF) begin
            underflow_count <= underflow_count + 16'd1;
         end
`endif
      end
   end

   // Data and clock shift registers: load at a boundary, shift otherwise.
   always_ff @(posedge clk_pixel_x5 or posedge reset) begin
      if (reset) begin
         shift_reg   <= {NUM_CHANNELS{IDLE_WORD}};
         clock_shift <= CLOCK_WORD;
      end else if (boundary) begin
         shift_reg   <= pop ? mem[rd_ptr] : {NUM_CHANNELS{IDLE_WORD}};
         clock_shift <= CLOCK_WORD;
      end else begin
         for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            shift_reg[ch] <= shift_reg[ch] >> BITS_PER_CYCLE;
         end
         clock_shift <= {clock_shift[BITS_PER_CYCLE-1:0], clock_shift[9:BITS_PER_CYCLE]};
      end
   end

   // Lane outputs are taken straight from the low bits of each shift register.
   always_comb begin
      // NOTE: default assignment first so no path leaves the output unassigned
      // (which would infer a latch).
      tmds_lane = '0;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         tmds_lane[ch*BITS_PER_CYCLE +: BITS_PER_CYCLE] = shift_reg[ch][BITS_PER_CYCLE-1:0];
      end
   end

   assign tmds_clock_lane = clock_shift[BITS_PER_CYCLE-1:0];

endmodule

// File: tb/tb_tmds_stream_serializer.sv
// Testbench for tmds_stream_serializer: a vector table for the first word
// after reset, a 1-bit-per-cycle instance for the bit ordering, hand
// sequences for full/streaming/reset corners, and random stimulus checked
// against a word-level reference model.
module tb_tmds_stream_serializer;

   localparam int         NC   = 3;
   localparam int         B    = 2;
   localparam int         D    = 4;
   localparam int         WC   = 10 / B;
   localparam logic [9:0] IDLE = 10'b1101010100;
   localparam logic [9:0] CLKW = 10'b0000011111;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              enable = 1'b0;
   logic              word_valid = 1'b0;
   logic              word_ready;
   logic [NC*10-1:0]  tmds_internal = '0;
   logic [NC*B-1:0]   tmds_lane;
   logic [B-1:0]      tmds_clock_lane;
   logic [2:0]        fifo_level;
   logic              underflow;

   logic              enable1 = 1'b0;
   logic              word_valid1 = 1'b0;
   logic              word_ready1;
   logic [9:0]        tmds_internal1 = '0;
   logic [0:0]        tmds_lane1;
   logic [0:0]        tmds_clock_lane1;
   logic [2:0]        fifo_level1;
   logic              underflow1;
`ifdef TMDS_SERIALIZER_UNDERFLOW_COUNT_EN
   logic [15:0]       underflow_count;
   logic [15:0]       underflow_count1;
`endif

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   tmds_stream_serializer #(
      .NUM_CHANNELS(NC), .BITS_PER_CYCLE(B), .FIFO_DEPTH(D), .IDLE_WORD(IDLE)
   ) u_dut (
      .clk_pixel_x5(clk), .reset(reset), .enable(enable), .word_valid(word_valid),
      .word_ready(word_ready), .tmds_internal(tmds_internal), .tmds_lane(tmds_lane),
      .tmds_clock_lane(tmds_clock_lane), .fifo_level(fifo_level), .underflow(underflow)
`ifdef TMDS_SERIALIZER_UNDERFLOW_COUNT_EN
      , .underflow_count(underflow_count)
`endif
   );

   tmds_stream_serializer #(
      .NUM_CHANNELS(1), .BITS_PER_CYCLE(1), .FIFO_DEPTH(4), .IDLE_WORD(IDLE)
   ) u_dut1 (
      .clk_pixel_x5(clk), .reset(reset), .enable(enable1), .word_valid(word_valid1),
      .word_ready(word_ready1), .tmds_internal(tmds_internal1), .tmds_lane(tmds_lane1),
      .tmds_clock_lane(tmds_clock_lane1), .fifo_level(fifo_level1), .underflow(underflow1)
`ifdef TMDS_SERIALIZER_UNDERFLOW_COUNT_EN
      , .underflow_count(underflow_count1)
`endif
   );

   // ---------------- reference model (word level) ----------------
   logic [NC*10-1:0] m_q[$];
   logic [NC*10-1:0] m_cur;
   int               m_phase;
   bit               m_run;
   bit               m_uf;
   int               m_cnt;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end else begin
         passed++;
      end
   endtask

   function automatic void model_reset();
      m_q.delete();
      m_cur   = {NC{IDLE}};
      m_phase = 0;
      m_run   = 0;
      m_uf    = 0;
      m_cnt   = 0;
   endfunction

   // One clock edge of the specified behaviour, given the inputs held across it.
   function automatic void model_step(input bit en, input bit v, input logic [NC*10-1:0] d);
      int sz = m_q.size();
      if (m_phase == WC - 1) begin
         if (en && sz > 0) begin
            m_cur = m_q.pop_front();
            m_run = 1;
         end else begin
            if (m_run && en) begin
               m_uf = 1;
               if (m_cnt != 16'hFFFF) m_cnt++;
            end
            if (!en) m_run = 0;
            m_cur = {NC{IDLE}};
         end
         m_phase = 0;
      end else begin
         m_phase++;
      end
      if (v && sz != D) m_q.push_back(d);
   endfunction

   task automatic check_outputs(input string tag);
      logic [NC*B-1:0] exp_lane;
      logic [9:0]      w;
      for (int ch = 0; ch < NC; ch++) begin
         w = m_cur[ch*10 +: 10] >> (m_phase * B);
         exp_lane[ch*B +: B] = w[B-1:0];
      end
      w = CLKW >> (m_phase * B);
      check({tag, " lane"},  64'(tmds_lane), 64'(exp_lane));
      check({tag, " clock"}, 64'(tmds_clock_lane), 64'(w[B-1:0]));
      check({tag, " level"}, 64'(fifo_level), 64'(m_q.size()));
      check({tag, " ready"}, 64'(word_ready), 64'(m_q.size() != D));
      check({tag, " underflow"}, 64'(underflow), 64'(m_uf));
`ifdef TMDS_SERIALIZER_UNDERFLOW_COUNT_EN
      check({tag, " underflow_count"}, 64'(underflow_count), 64'(m_cnt));
`endif
   endtask

   // Drive one cycle from a negedge, advance the model at the posedge, check at the next negedge.
   task automatic step(input string tag, input bit en, input bit v, input logic [NC*10-1:0] d);
      enable        = en;
      word_valid    = v;
      tmds_internal = d;
      @(posedge clk);
      model_step(en, v, d);
      @(negedge clk);
      check_outputs(tag);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      enable = 0; word_valid = 0; tmds_internal = '0;
      enable1 = 0; word_valid1 = 0; tmds_internal1 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   typedef struct {
      bit               en;
      bit               valid;
      logic [NC*10-1:0] data;
      logic [1:0]       lane0;
      logic [1:0]       clk_bits;
      int               level;
      bit               uf;
   } vec_t;

   vec_t vecs[11];

   initial begin
      logic [9:0]       idle_v;
      logic [NC*10-1:0] d;
      int               seq;
      int               pushed;
      bit               was_boundary;
      bit               did_push;
      int               pv;
      int               pe;

      // First word after reset: pushed in cycle 1, taken at the cycle-4 boundary,
      // all ones on lane 0 for cycles 5..9, then underflow at the cycle-9 boundary.
      vecs[0]  = '{1'b1, 1'b0, 30'h0,   2'b00, 2'b11, 0, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 30'h3FF, 2'b01, 2'b11, 0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 30'h0,   2'b01, 2'b01, 1, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 30'h0,   2'b01, 2'b00, 1, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 30'h0,   2'b11, 2'b00, 1, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 30'h0,   2'b11, 2'b11, 0, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 30'h0,   2'b11, 2'b11, 0, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 30'h0,   2'b11, 2'b01, 0, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 30'h0,   2'b11, 2'b00, 0, 1'b0};
      vecs[9]  = '{1'b1, 1'b0, 30'h0,   2'b11, 2'b00, 0, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 30'h0,   2'b00, 2'b11, 0, 1'b1};

      // Reset state while reset is held.
      #12;
      check("reset lane", 64'(tmds_lane), 64'(0));
      check("reset clock", 64'(tmds_clock_lane), 64'(2'b11));
      check("reset level", 64'(fifo_level), 64'(0));
      check("reset ready", 64'(word_ready), 64'(1));
      check("reset underflow", 64'(underflow), 64'(0));

      do_reset();
      for (int k = 0; k < 11; k++) begin
         check($sformatf("vec%0d lane0", k), 64'(tmds_lane[1:0]), 64'(vecs[k].lane0));
         check($sformatf("vec%0d clock", k), 64'(tmds_clock_lane), 64'(vecs[k].clk_bits));
         check($sformatf("vec%0d level", k), 64'(fifo_level), 64'(vecs[k].level));
         check($sformatf("vec%0d underflow", k), 64'(underflow), 64'(vecs[k].uf));
         enable = vecs[k].en; word_valid = vecs[k].valid; tmds_internal = vecs[k].data;
         @(posedge clk);
         @(negedge clk);
      end
`ifdef TMDS_SERIALIZER_UNDERFLOW_COUNT_EN
      check("vec underflow_count", 64'(underflow_count), 64'(1));
`endif

      // One bit per cycle: word 1 pushed in cycle 1, taken at the cycle-9 boundary.
      do_reset();
      idle_v = IDLE;
      for (int k = 0; k < 20; k++) begin
         check($sformatf("b1 lane c%0d", k), 64'(tmds_lane1),
               64'((k < 10) ? idle_v[k] : (k == 10)));
         check($sformatf("b1 clock c%0d", k), 64'(tmds_clock_lane1), 64'((k % 10) < 5));
         enable1 = 1'b1; word_valid1 = (k == 1); tmds_internal1 = 10'b0000000001;
         @(posedge clk);
         @(negedge clk);
      end
      enable1 = 0; word_valid1 = 0;

      // Fill while disabled: the FIFO stops at its depth and refuses extra words.
      do_reset();
      check_outputs("fill c0");
      seq = 0;
      for (int k = 0; k < 8; k++) begin
         seq++;
         step("fill", 1'b0, 1'b1, 30'(seq * 7919 + 1));
      end
      check("fill level full", 64'(fifo_level), 64'(4));
      check("fill ready low", 64'(word_ready), 64'(0));
      for (int k = 0; k < 30; k++) step("drain", 1'b1, 1'b0, '0);
      check("drain level empty", 64'(fifo_level), 64'(0));

      // Streaming at level 2: push coincides with pop at each boundary, 20 words.
      do_reset();
      check_outputs("stream c0");
      pushed = 0;
      for (int c = 0; c < 200 && pushed < 20; c++) begin
         was_boundary = (m_phase == WC - 1);
         did_push = (c < 2) || was_boundary;
         d = 30'(pushed * 104729 + 17);
         step("stream", 1'b1, did_push, d);
         if (did_push) pushed++;
         if (was_boundary && pushed > 2)
            check("stream level held", 64'(fifo_level), 64'(2));
      end
      for (int k = 0; k < 20; k++) step("stream drain", 1'b1, 1'b0, '0);

      // Reset at phase 2 of a running word aborts it and discards the FIFO.
      do_reset();
      check_outputs("abort c0");
      for (int k = 0; k < 4; k++) step("abort load", 1'b1, 1'b1, 30'(k * 31 + 5));
      while (!(m_run && m_phase == 2)) step("abort run", 1'b1, 1'b0, '0);
      reset = 1'b1;
      #1;
      check("abort lane", 64'(tmds_lane), 64'(0));
      check("abort clock", 64'(tmds_clock_lane), 64'(2'b11));
      check("abort level", 64'(fifo_level), 64'(0));
      check("abort ready", 64'(word_ready), 64'(1));
      check("abort underflow", 64'(underflow), 64'(0));
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      for (int k = 0; k < 12; k++) step("after abort", 1'b1, 1'b0, '0);

      // Random traffic in blocks of varying push rate and enable duty.
      do_reset();
      check_outputs("rand c0");
      for (int blk = 0; blk < 15; blk++) begin
         pv = $urandom_range(90, 10);
         pe = (blk % 3 == 2) ? 60 : 98;
         for (int i = 0; i < 200; i++) begin
            step("rand", $urandom_range(99) < pe, $urandom_range(99) < pv, 30'($urandom));
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
